top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 268 ++++++++++++++++++++++++++
 tb/tb_top.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
`timescale 1ns/1ps
// UART block XOR engine: gathers 16 received 8N1 bytes, XORs the block with KEY, and sends the 16 result bytes back.
// Latency: Tx start bit begins on the same edge that the output register loads, one clock after the 16th byte is stored.
// Backpressure: none on the serial line. Bytes that finish while the transmitter is busy are dropped and not counted.
// Ports: Clk - system clock, rising edge; Rst - synchronous active-high reset;
//        Rx  - asynchronous serial input, idle high; Tx - registered serial output, idle high.
module top #(
  parameter int           CLKS_PER_BIT = 434,
  parameter logic [127:0] KEY          = 128'h2B7E151628AED2A6ABF7158809CF4F3C
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Rx,
  output logic Tx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- input synchronizer and arming ----------------
  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          r_armed;
  logic [CW-1:0] r_arm_cnt;

  // ---------------- receiver ----------------
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_byte_vld, w_frame_err;

  // ---------------- block assembly ----------------
  logic [127:0]  r_block, r_out;
  logic [3:0]    r_byte_cnt;
  logic          r_load_pend;
  logic          w_tx_busy, w_store;
  logic [6:0]    w_rx_base;

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [3:0]    r_tx_idx, w_tx_idx_nxt;
  logic          r_tx, w_tx_nxt;
  logic [6:0]    w_tx_base;
  logic [7:0]    w_tx_byte;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // The receiver only listens after a full bit time of continuous idle, so a
  // line stuck low (or a broken frame) cannot be mistaken for a start bit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end else if (w_frame_err) begin
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end else if (!r_armed) begin
      if (!r_rx_sync) begin
        r_arm_cnt <= '0;
      end else if (r_arm_cnt == BIT_LAST) begin
        r_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_byte_vld     = 1'b0;
    w_frame_err    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_armed && r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bit_nxt   = '0;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};  // LSB arrives first
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_sync) begin
            w_byte_vld = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Byte n of the block lives at bits [127-8n -: 8], i.e. base = (15-n)*8.
  assign w_rx_base = {~r_byte_cnt, 3'b000};
  assign w_tx_busy = (r_tx_state != TX_IDLE) || r_load_pend;
  assign w_store   = w_byte_vld && !w_tx_busy;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_block     <= '0;
      r_out       <= '0;
      r_byte_cnt  <= '0;
      r_load_pend <= 1'b0;
    end else begin
      r_load_pend <= 1'b0;
      if (w_store) begin
        r_block[w_rx_base +: 8] <= r_rx_shift;
        r_byte_cnt              <= r_byte_cnt + 4'd1;
        r_load_pend             <= (r_byte_cnt == 4'hF);
      end
      if (r_load_pend) begin
        r_out <= r_block ^ KEY;
      end
    end
  end

  assign w_tx_base = {~r_tx_idx, 3'b000};
  assign w_tx_byte = r_out[w_tx_base +: 8];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_idx   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // The line level for the next bit is decided at each bit boundary and
  // registered, so Tx changes exactly once per bit and never glitches.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_nxt       = r_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        // Start bit goes out on the same edge the output register loads;
        // the first data bit is read from r_out a full bit later.
        if (r_load_pend) begin
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = w_tx_byte[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_bit_nxt = r_tx_bit + 3'd1;
            w_tx_nxt     = w_tx_byte[r_tx_bit + 3'd1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 4'hF) begin
            w_tx_state_nxt = TX_IDLE;
            w_tx_nxt       = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            w_tx_state_nxt = TX_START;
            w_tx_idx_nxt   = r_tx_idx + 4'd1;
            w_tx_nxt       = 1'b0;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_nxt       = 1'b1;
      end
    endcase
  end

  assign Tx = r_tx;

endmodule

// File: tb/tb_top.sv
`timescale 1ns/1ps
// Bench for the UART block XOR engine: a driver sends 8N1 frames on Rx, a
// reference model decides which 16-byte blocks complete and queues the
// expected output bytes, and an independent monitor decodes Tx frames.
module tb_top;

  localparam int           CPB = 16;
  localparam logic [127:0] KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] BLK_A = 128'h3243F6A8885A308D313198A2E0370734;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Rx  = 1'b0;
  logic Tx;

  top #(.CLKS_PER_BIT(CPB), .KEY(KEY)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Tx(Tx)
  );

  initial begin
    #5;
    forever begin
      Clk = 1'b1; #10;
      Clk = 1'b0; #10;
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_blk[$];
  int  t_stop = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a completed byte joins the pending block unless an
  // output block is still outstanding; 16 bytes yield block XOR KEY.
  task automatic model_rx(input logic [7:0] b);
    logic [127:0] k;
    k = KEY;
    if (exp_q.size() != 0) return;
    model_blk.push_back(b);
    if (model_blk.size() == 16) begin
      for (int i = 0; i < 16; i++) exp_q.push_back(model_blk[i] ^ k[127-8*i -: 8]);
      model_blk.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    @(negedge Clk);
    Rx = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (CPB) @(negedge Clk);
    end
    t_stop = cyc;
    Rx = good;
    repeat (CPB) @(negedge Clk);
    Rx = 1'b1;
    if (good) model_rx(b);
    else repeat (2*CPB) @(negedge Clk);
    repeat ($urandom_range(0, 3)) @(negedge Clk);
  endtask

  task automatic send_block(input logic [127:0] d);
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8], 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge Clk);
      n++;
    end
    check("output_drained", 128'(exp_q.size()), 128'd0);
    repeat (2*CPB) @(negedge Clk);
  endtask

  // Monitor: decodes Tx frames, checks framing, block-start latency,
  // back-to-back spacing, and compares each byte with the queue head.
  initial begin
    int frames;
    int start;
    int last_start;
    logic [7:0] b;
    frames = 0;
    last_start = 0;
    forever begin
      @(negedge Clk);
      if (mon_en && Tx === 1'b0) begin
        start = cyc;
        if (frames % 16 == 0) begin
          checks++;
          if (start - t_stop < CPB/2 || start - t_stop > CPB/2 + 8) begin
            errors++;
            $display("FAIL block_latency: start %0d cycles after last stop bit began, required %0d..%0d",
                     start - t_stop, CPB/2, CPB/2 + 8);
          end
        end else begin
          check("frame_spacing", 128'(start - last_start), 128'(10*CPB));
        end
        last_start = start;
        repeat (CPB/2) @(negedge Clk);
        check("start_bit", 128'(Tx), 128'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clk);
          b[i] = Tx;
        end
        repeat (CPB) @(negedge Clk);
        check("stop_bit", 128'(Tx), 128'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h required no frame", b);
        end else begin
          check("tx_byte", 128'(b), 128'(exp_q.pop_front()));
        end
        frames++;
      end
    end
  end

  initial begin
    #1_800_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, %0d bytes still expected", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lows;
    logic [127:0] d;

    // Rx low from time 0 through reset and beyond: no frames, Tx stays high.
    Rx = 1'b0;
    #100 Rst = 1'b1;
    #30  Rst = 1'b0;
    mon_en = 1'b1;
    @(negedge Clk);
    check("reset_tx_high", 128'(Tx), 128'd1);
    lows = 0;
    repeat (30*CPB) begin
      @(negedge Clk);
      if (Tx !== 1'b1) lows++;
    end
    check("rx_low_no_tx", 128'(lows), 128'd0);

    Rx = 1'b1;
    repeat (2*CPB) @(negedge Clk);

    // Known block and all-zero block (output equals KEY).
    send_block(BLK_A);
    wait_idle();
    send_block(128'd0);
    wait_idle();

    // Framing error in the middle of a block.
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) send_byte(d[127-8*i -: 8], 1'b1);
    send_byte(8'h5A, 1'b0);
    for (int i = 8; i < 16; i++) send_byte(d[127-8*i -: 8], 1'b1);
    wait_idle();

    // Partial block then reset: partial data is discarded.
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) send_byte(d[127-8*i -: 8], 1'b1);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check("tx_high_in_reset", 128'(Tx), 128'd1);
    end
    Rst = 1'b0;
    model_blk.delete();
    repeat (2*CPB) @(negedge Clk);
    send_block(BLK_A);
    wait_idle();

    // 17th byte during transmission is dropped; next block counts from 0.
    d = {$urandom, $urandom, $urandom, $urandom};
    send_block(d);
    send_byte(8'($urandom), 1'b1);
    wait_idle();
    d = {$urandom, $urandom, $urandom, $urandom};
    send_block(d);
    wait_idle();

    check("model_partial_empty", 128'(model_blk.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
